// File: rtl/csr_timer_intc_pkg.sv
// Shared definitions for the timer / interrupt-status CSR slice: CSR numbers,
// TCFG field layout, ESTAT.IS bit positions, access masks and the write-merge helper.
package cpuDefine;

  typedef enum logic [13:0] {
    CSR_ESTAT = 14'h005,
    CSR_TID   = 14'h040,
    CSR_TCFG  = 14'h041,
    CSR_TVAL  = 14'h042,
    CSR_TICLR = 14'h044
  } csr_num_e;

  typedef struct packed {
    logic [29:0] init_val;
    logic        periodic;
    logic        en;
  } tcfg_t;

  localparam int IS_WIDTH  = 13;
  localparam int IS_SWI_LO = 0;
  localparam int IS_HWI_LO = 2;
  localparam int IS_TI     = 11;
  localparam int IS_IPI    = 12;

  localparam logic [31:0] TID_WMASK   = 32'hFFFF_FFFF;
  localparam logic [31:0] ESTAT_WMASK = 32'h0000_0003;
  localparam logic [31:0] ESTAT_RMASK = 32'h0000_1BFF;
  localparam logic [31:0] TICLR_WMASK = 32'h0000_0001;

  // TCFG is writable only up to the configured countdown width.
  function automatic logic [31:0] tcfg_wmask(input int tw);
    return 32'hFFFF_FFFF >> (32 - tw);
  endfunction

  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [31:0] wmask,
                                            input logic [31:0] writable);
    return ((old_val & ~wmask) | (wdata & wmask)) & writable;
  endfunction

endpackage

// File: rtl/csr_timer_core.sv
// Countdown timer: holds TVAL, handles TCFG loads and periodic reloads, and
// flags the cycle in which TVAL steps from 1 to 0.
module csr_timer_core #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_val,
  input  logic                   en,
  input  logic                   periodic,
  input  logic [TIMER_WIDTH-1:0] reload_val,
  output logic [TIMER_WIDTH-1:0] tval,
  output logic                   fire
);

  localparam logic [TIMER_WIDTH-1:0] TVAL_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  logic [TIMER_WIDTH-1:0] tval_r;
  logic [TIMER_WIDTH-1:0] tval_nxt_s;
  logic                   fire_s;

  // Fire on the 1->0 step; a coinciding TCFG load still counts as a fire.
  always_comb begin
    fire_s = en && (tval_r == TVAL_ONE);
  end

  // Next TVAL: a load always wins, otherwise count down / reload / hold.
  always_comb begin
    tval_nxt_s = tval_r;
    if (load) begin
      tval_nxt_s = load_val;
    end else if (en) begin
      if (tval_r != '0) begin
        tval_nxt_s = tval_r - TVAL_ONE;
      end else if (periodic) begin
        tval_nxt_s = reload_val;
      end else begin
        tval_nxt_s = '0;
      end
    end else begin
      tval_nxt_s = tval_r;
    end
  end

  // TVAL state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tval_r <= '0;
    end else begin
      tval_r <= tval_nxt_s;
    end
  end

  assign tval = tval_r;
  assign fire = fire_s;

endmodule

// File: rtl/csr_timer_intc.sv
// Timer and interrupt-status CSR block: TID/TCFG/TVAL/TICLR/ESTAT registers,
// ESTAT.IS collection, registered irq and a free-running stable counter.
module csr_timer_intc
  import cpuDefine::*;
#(
  parameter int TIMER_WIDTH = 32,
  parameter int NUM_HWI     = 8,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 csr_we,
  input  logic [13:0]          csr_waddr,
  input  logic [31:0]          csr_wdata,
  input  logic [31:0]          csr_wmask,
  input  logic [13:0]          csr_raddr,
  output logic [31:0]          csr_rdata,
  input  logic [NUM_HWI-1:0]   hw_int,
  input  logic                 ipi,
  input  logic [12:0]          lie,
  input  logic                 ie,
  output logic [12:0]          is,
  output logic                 irq,
  output logic [CNT_WIDTH-1:0] stable_cnt
);

  localparam logic [31:0]          TCFG_WMASK = tcfg_wmask(TIMER_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]            tcfg_r;
  logic [31:0]            tid_r;
  logic [1:0]             swi_r;
  logic [7:0]             hwi_r;
  logic                   ipi_r;
  logic                   ti_r;
  logic                   irq_r;
  logic [CNT_WIDTH-1:0]   cnt_r;

  logic                   tcfg_we_s;
  logic                   tid_we_s;
  logic                   estat_we_s;
  logic                   ticlr_s;
  logic [31:0]            tcfg_new_s;
  logic [31:0]            tid_new_s;
  logic [1:0]             swi_new_s;
  logic [7:0]             hwi_in_s;
  tcfg_t                  tcfg_view_s;
  tcfg_t                  tcfg_new_view_s;
  logic [TIMER_WIDTH-1:0] reload_s;
  logic [TIMER_WIDTH-1:0] load_val_s;
  logic [TIMER_WIDTH-1:0] tval_s;
  logic                   fire_s;
  logic [12:0]            is_s;
  logic [31:0]            rdata_s;
  logic                   irq_nxt_s;

  // Write decode and merged write values for each writable CSR.
  always_comb begin
    tcfg_we_s  = csr_we && (csr_waddr == CSR_TCFG);
    tid_we_s   = csr_we && (csr_waddr == CSR_TID);
    estat_we_s = csr_we && (csr_waddr == CSR_ESTAT);
    ticlr_s    = csr_we && (csr_waddr == CSR_TICLR)
                 && (csr_merge(32'h0, csr_wdata, csr_wmask, TICLR_WMASK) != 32'h0);
    tcfg_new_s = csr_merge(tcfg_r, csr_wdata, csr_wmask, TCFG_WMASK);
    tid_new_s  = csr_merge(tid_r, csr_wdata, csr_wmask, TID_WMASK);
    swi_new_s  = 2'(csr_merge({19'h0, is_s}, csr_wdata, csr_wmask, ESTAT_WMASK) >> IS_SWI_LO);
    hwi_in_s   = 8'(hw_int);
  end

  // InitVal is stored pre-scaled by 4: the countdown value is {InitVal, 2'b00}.
  always_comb begin
    tcfg_view_s     = tcfg_t'(tcfg_r);
    tcfg_new_view_s = tcfg_t'(tcfg_new_s);
    reload_s        = TIMER_WIDTH'({tcfg_view_s.init_val, 2'b00});
    load_val_s      = TIMER_WIDTH'({tcfg_new_view_s.init_val, 2'b00});
  end

  csr_timer_core #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer_core (
    .clk        (clk),
    .reset      (reset),
    .load       (tcfg_we_s),
    .load_val   (load_val_s),
    .en         (tcfg_view_s.en),
    .periodic   (tcfg_view_s.periodic),
    .reload_val (reload_s),
    .tval       (tval_s),
    .fire       (fire_s)
  );

  // Assemble ESTAT.IS from its registered sources; bit 10 is reserved.
  always_comb begin
    is_s                       = 13'h0;
    is_s[IS_SWI_LO +: 2]       = swi_r;
    is_s[IS_HWI_LO +: 8]       = hwi_r;
    is_s[IS_TI]                = ti_r;
    is_s[IS_IPI]               = ipi_r;
    irq_nxt_s                  = ie && ((is_s & lie) != 13'h0);
  end

  // Combinational read mux; reads see pre-edge state.
  always_comb begin
    rdata_s = 32'h0;
    case (csr_raddr)
      CSR_ESTAT: rdata_s = {19'h0, is_s} & ESTAT_RMASK;
      CSR_TID:   rdata_s = tid_r;
      CSR_TCFG:  rdata_s = tcfg_r & TCFG_WMASK;
      CSR_TVAL:  rdata_s = 32'(tval_s);
      CSR_TICLR: rdata_s = 32'h0;
      default:   rdata_s = 32'h0;
    endcase
  end

  // CSR state, interrupt sync registers, irq and the stable counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_r <= 32'h0;
      tid_r  <= 32'h0;
      swi_r  <= 2'b00;
      hwi_r  <= 8'h00;
      ipi_r  <= 1'b0;
      ti_r   <= 1'b0;
      irq_r  <= 1'b0;
      cnt_r  <= '0;
    end else begin
      if (tcfg_we_s) begin
        tcfg_r <= tcfg_new_s;
      end
      if (tid_we_s) begin
        tid_r <= tid_new_s;
      end
      if (estat_we_s) begin
        swi_r <= swi_new_s;
      end
      // A timer fire beats a simultaneous TICLR clear.
      if (fire_s) begin
        ti_r <= 1'b1;
      end else if (ticlr_s) begin
        ti_r <= 1'b0;
      end
      hwi_r <= hwi_in_s;
      ipi_r <= ipi;
      irq_r <= irq_nxt_s;
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign csr_rdata  = rdata_s;
  assign is         = is_s;
  assign irq        = irq_r;
  assign stable_cnt = cnt_r;

endmodule

// File: tb/tb_csr_timer_intc.sv
// Directed bench for csr_timer_intc: a cycle-level reference model checked every
// cycle, plus hand-computed literal expectations for timer, IS, irq and reset behaviour.
module tb_csr_timer_intc;

  localparam logic [13:0] A_ESTAT = 14'h005;
  localparam logic [13:0] A_TID   = 14'h040;
  localparam logic [13:0] A_TCFG  = 14'h041;
  localparam logic [13:0] A_TVAL  = 14'h042;
  localparam logic [13:0] A_TICLR = 14'h044;
  localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [7:0]  hw_int;
  logic        ipi;
  logic [12:0] lie;
  logic        ie;
  logic [12:0] is;
  logic        irq;
  logic [63:0] stable_cnt;

  csr_timer_intc dut (
    .clk        (clk),
    .reset      (reset),
    .csr_we     (csr_we),
    .csr_waddr  (csr_waddr),
    .csr_wdata  (csr_wdata),
    .csr_wmask  (csr_wmask),
    .csr_raddr  (csr_raddr),
    .csr_rdata  (csr_rdata),
    .hw_int     (hw_int),
    .ipi        (ipi),
    .lie        (lie),
    .ie         (ie),
    .is         (is),
    .irq        (irq),
    .stable_cnt (stable_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: architectural state stepped once per clock edge.
  logic [31:0] m_tcfg, m_tval, m_tid, m_wnew;
  logic [1:0]  m_swi;
  logic [7:0]  m_hwi;
  logic        m_ipi, m_ti, m_irq, m_fire;
  logic [63:0] m_cnt;
  logic        m_valid = 1'b0;

  function automatic logic [12:0] m_is();
    return {m_ipi, m_ti, 1'b0, m_hwi, m_swi};
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    case (a)
      A_ESTAT: return {19'h0, m_is()};
      A_TID:   return m_tid;
      A_TCFG:  return m_tcfg;
      A_TVAL:  return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_tcfg = 0; m_tval = 0; m_tid = 0; m_swi = 0; m_hwi = 0;
      m_ipi = 0; m_ti = 0; m_irq = 0; m_cnt = 0; m_valid = 1'b1;
    end else begin
      m_wnew = csr_wdata & csr_wmask;
      m_irq  = ie && ((m_is() & lie) != 13'h0);
      m_fire = m_tcfg[0] && (m_tval == 32'd1);
      if (csr_we && csr_waddr == A_TCFG) begin
        m_tcfg = (m_tcfg & ~csr_wmask) | m_wnew;
        m_tval = m_tcfg & 32'hFFFF_FFFC;
      end else if (m_tcfg[0]) begin
        if (m_tval != 0) m_tval = m_tval - 1;
        else if (m_tcfg[1]) m_tval = m_tcfg & 32'hFFFF_FFFC;
      end
      if (m_fire) m_ti = 1'b1;
      else if (csr_we && csr_waddr == A_TICLR && m_wnew[0]) m_ti = 1'b0;
      if (csr_we && csr_waddr == A_ESTAT) m_swi = (m_swi & ~csr_wmask[1:0]) | m_wnew[1:0];
      if (csr_we && csr_waddr == A_TID) m_tid = (m_tid & ~csr_wmask) | m_wnew;
      m_hwi = hw_int;
      m_ipi = ipi;
      m_cnt = m_cnt + 64'd1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("is", 64'(is), 64'(m_is()));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("stable_cnt", stable_cnt, m_cnt);
      chk("rdata", 64'(csr_rdata), 64'(m_read(csr_raddr)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d; csr_wmask = m;
    tick(1);
    csr_we = 1'b0; csr_wmask = 32'h0;
  endtask

  task automatic read_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    chk(name, 64'(csr_rdata), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset = 1'b1; csr_we = 1'b0; csr_waddr = 14'h0; csr_wdata = 32'h0; csr_wmask = 32'h0;
    csr_raddr = 14'h0; hw_int = 8'h0; ipi = 1'b0; lie = 13'h0; ie = 1'b0;
    tick(2);
    chk("reset_is", 64'(is), 64'd0);
    chk("reset_irq", 64'(irq), 64'd0);
    chk("reset_cnt", stable_cnt, 64'd0);
    reset = 1'b0;
    tick(3);
    chk("cnt_after_3", stable_cnt, 64'd3);

    // One-shot countdown from 20.
    csr_write(A_TCFG, 32'h0000_0015, ONES);
    read_chk("oneshot_load", A_TVAL, 32'd20);
    tick(19);
    read_chk("oneshot_at_1", A_TVAL, 32'd1);
    chk("oneshot_no_ti_yet", 64'(is[11]), 64'd0);
    tick(1);
    read_chk("oneshot_at_0", A_TVAL, 32'd0);
    chk("oneshot_ti_set", 64'(is[11]), 64'd1);
    csr_write(A_TICLR, 32'h1, 32'h1);
    chk("oneshot_ti_cleared", 64'(is[11]), 64'd0);
    tick(30);
    read_chk("oneshot_holds_0", A_TVAL, 32'd0);
    chk("oneshot_no_refire", 64'(is[11]), 64'd0);

    // Periodic countdown from 8: fires every 9 cycles.
    csr_write(A_TCFG, 32'h0000_000B, ONES);
    k = 0;
    while (is[11] !== 1'b1 && k < 40) begin tick(1); k++; end
    chk("periodic_first_fire", 64'(k), 64'd8);
    csr_write(A_TICLR, 32'h1, 32'h1);
    chk("periodic_clr", 64'(is[11]), 64'd0);
    k = 1;
    while (is[11] !== 1'b1 && k < 40) begin tick(1); k++; end
    chk("periodic_interval", 64'(k), 64'd9);

    // TICLR on the same edge as the 1->0 step: the set wins.
    csr_write(A_TICLR, 32'h1, 32'h1);
    tick(7);
    read_chk("periodic_at_1", A_TVAL, 32'd1);
    csr_write(A_TICLR, 32'h1, 32'h1);
    chk("clr_vs_fire", 64'(is[11]), 64'd1);

    // TCFG write on the 1->0 step: load wins for TVAL, TI still sets.
    csr_write(A_TICLR, 32'h1, 32'h1);
    tick(7);
    csr_write(A_TCFG, 32'h0000_0015, ONES);
    read_chk("tcfg_beats_dec", A_TVAL, 32'd20);
    chk("ti_with_tcfg", 64'(is[11]), 64'd1);

    // En=0 holds TVAL; loading 0 with En=1 does not fire.
    csr_write(A_TCFG, 32'h0000_0014, ONES);
    tick(5);
    read_chk("en0_hold", A_TVAL, 32'd20);
    csr_write(A_TICLR, 32'h1, 32'h1);
    csr_write(A_TCFG, 32'h0000_0001, ONES);
    tick(5);
    chk("zero_load_no_fire", 64'(is[11]), 64'd0);

    // Hardware interrupt path latency and the ie gate.
    lie = 13'h020; ie = 1'b1; hw_int = 8'h08;
    tick(1);
    chk("hwi3_is5", 64'(is[5]), 64'd1);
    chk("irq_not_yet", 64'(irq), 64'd0);
    tick(1);
    chk("irq_asserted", 64'(irq), 64'd1);
    ie = 1'b0;
    tick(2);
    chk("irq_ie0", 64'(irq), 64'd0);
    hw_int = 8'h00; ipi = 1'b1;
    tick(1);
    chk("ipi_is12", 64'(is[12]), 64'd1);
    ipi = 1'b0; lie = 13'h0;
    tick(1);

    // ESTAT masked write, TID partial write, read-before-write, unmapped CSRs.
    csr_write(A_ESTAT, ONES, 32'h0000_0001);
    read_chk("estat_swi0_only", A_ESTAT, 32'h0000_0001);
    csr_write(A_TID, 32'h1234_5678, ONES);
    csr_raddr = A_TID; csr_we = 1'b1; csr_waddr = A_TID;
    csr_wdata = 32'hABCD_EF01; csr_wmask = 32'hFFFF_0000;
    #1;
    chk("read_pre_edge", 64'(csr_rdata), 64'h1234_5678);
    tick(1);
    csr_we = 1'b0; csr_wmask = 32'h0;
    read_chk("tid_upper_only", A_TID, 32'hABCD_5678);
    csr_write(14'h043, ONES, ONES);
    read_chk("unmapped_reads_0", 14'h043, 32'h0);
    read_chk("ticlr_reads_0", A_TICLR, 32'h0);

    // Reset during a periodic countdown.
    csr_write(A_TCFG, 32'h0000_000B, ONES);
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("rst_is", 64'(is), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_cnt", stable_cnt, 64'd0);
    reset = 1'b0;
    read_chk("rst_tval", A_TVAL, 32'd0);
    tick(20);
    chk("rst_no_ti", 64'(is[11]), 64'd0);
    read_chk("rst_tcfg", A_TCFG, 32'd0);
    chk("rst_cnt_20", stable_cnt, 64'd20);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
